// File: rtl/axi_ic_pkg.sv
// Shared definitions for the AXI interconnect arbiters: FSM encoding and
// small elaboration/decode helpers.
package axi_ic_pkg;

  localparam int unsigned MAX_MST = 8;
  localparam int unsigned MAX_IW  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADDR = 2'b01,
    DATA = 2'b10,
    RESP = 2'b11
  } arb_state_e;

  // Ceiling log2, used for index and counter widths at elaboration
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r = r + 1;
    return r;
  endfunction

  function automatic logic [MAX_MST-1:0] onehot(input logic [MAX_IW-1:0] idx);
    logic [MAX_MST-1:0] r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request strictly after 'last', wrapping.
// Purely combinational; shared by the read and write arbiters.
module rr_pick
  import axi_ic_pkg::*;
#(
  parameter int unsigned N_MST = 2,
  parameter int unsigned IW    = clog2(N_MST)
) (
  input  logic [N_MST-1:0] req,
  input  logic [IW-1:0]    last,
  output logic [IW-1:0]    idx,
  output logic             any
);

  // Scan last+1 .. last+N_MST so 'last' itself has the lowest priority
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int unsigned k = 1; k <= N_MST; k++) begin
      if (!any && req[IW'((32'(last) + k) % N_MST)]) begin
        idx = IW'((32'(last) + k) % N_MST);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_wr_arbiter.sv
// Round-robin write-path arbiter: one write transaction at a time through
// address, data and response phases, with optional response timeout.
module axi_wr_arbiter
  import axi_ic_pkg::*;
#(
  parameter int unsigned N_MST   = 2,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [N_MST-1:0] req,
  input  logic             aw_hs,
  input  logic             w_last_hs,
  input  logic             b_hs,
  output logic [N_MST-1:0] aw_gnt,
  output logic [N_MST-1:0] w_gnt,
  output logic [N_MST-1:0] b_gnt,
  output logic             busy,
  output logic             timeout_err
);

  localparam int unsigned IW = clog2(N_MST);
  localparam int unsigned CW = (TIMEOUT == 0) ? 1 : clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  arb_state_e       state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [IW-1:0]    last_q, last_d;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             to_d;
  logic [N_MST-1:0] oh_d;
  logic [N_MST-1:0] aw_gnt_d, w_gnt_d, b_gnt_d;

  rr_pick #(
    .N_MST (N_MST),
    .IW    (IW)
  ) u_pick (
    .req  (req),
    .last (last_q),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // Next state; grants are decoded from the next state so they register cleanly
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    to_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = ADDR;
          idx_d   = pick_idx;
        end
      end
      ADDR: begin
        if (aw_hs) state_d = DATA;
      end
      DATA: begin
        cnt_d = '0;
        if (w_last_hs) state_d = RESP;
      end
      RESP: begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
        if (b_hs) begin
          state_d = IDLE;
          last_d  = idx_q;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          state_d = IDLE;
          last_d  = idx_q;
          to_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    oh_d     = N_MST'(onehot(MAX_IW'(idx_d)));
    aw_gnt_d = (state_d == ADDR) ? oh_d : '0;
    w_gnt_d  = (state_d == DATA) ? oh_d : '0;
    b_gnt_d  = (state_d == RESP) ? oh_d : '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      last_q      <= IW'(N_MST - 1);
      cnt_q       <= '0;
      aw_gnt      <= '0;
      w_gnt       <= '0;
      b_gnt       <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      aw_gnt      <= aw_gnt_d;
      w_gnt       <= w_gnt_d;
      b_gnt       <= b_gnt_d;
      busy        <= (state_d != IDLE);
      timeout_err <= to_d;
    end
  end

endmodule
